huffman_decoder: RTL and testbench
==================================

// Module: huffman_decoder
// PURPOSE
//  Inverse of the huffman encoder block: latches the 6-entry codebook (HC1..HC6 values, M1..M6
//  masks) published with code_valid, then decodes a serial bitstream (one bit per cycle) back
//  into gray symbols 1..6. Sits downstream of the encoder in the loop-back check path; its
//  sym_out stream is compared against the original gray_data sequence.
// PARAMETERS
//  MAX_LEN  8    longest legal code length in bits (= HC/M width)
//  NUM_SYM  100  symbols per frame; done pulses after this many are decoded
// PORTS
//  CLK         in   1  clock, all state on rising edge
//  reset       in   1  asynchronous, active-high
//  code_valid  in   1  1-cycle strobe: HC1..HC6/M1..M6 valid, load codebook
//  HC1..HC6    in   8  code for symbol i, right-aligned (bit0 = last bit sent)
//  M1..M6      in   8  mask for symbol i: contiguous ones from bit0, popcount = code length
//  bit_valid   in   1  bit_in valid this cycle
//  bit_in      in   1  next code bit, MSB of each code first
//  sym_valid   out  1  1-cycle pulse: sym_out holds a decoded symbol
//  sym_out     out  8  decoded symbol 1..6 (zero-extended)
//  err         out  1  1-cycle pulse: MAX_LEN bits accumulated with no codebook match
//  done        out  1  1-cycle pulse with the NUM_SYM-th sym_valid
//  sym_cnt     out  8  symbols decoded in current frame
// BEHAVIOUR
//  Reset: sym_valid=0, sym_out=0, err=0, done=0, sym_cnt=0; codebook regs and accumulator
//   cleared; state=S_EMPTY.
//  States: S_EMPTY (no codebook, bit_valid ignored) -> S_DECODE on code_valid.
//   S_DECODE -> S_DONE when done fires. S_DONE ignores bits; code_valid -> S_DECODE.
//  code_valid in any state: latch all 12 inputs, clear acc/len/sym_cnt, enter S_DECODE. A
//   bit_valid in the same cycle is dropped (load wins). No outputs pulse that cycle.
//  Decode (S_DECODE, bit_valid=1): acc_n = {acc[6:0],bit_in}, len_n = len+1. Entry i matches
//   iff M_i != 0, M_i == (2^len_n - 1), and (acc_n & M_i) == HC_i. Combinational match on
//   acc_n; outputs registered -> sym_valid rises the cycle after the completing bit (latency 1).
//  Match: sym_valid=1, sym_out=i, sym_cnt+1, acc/len cleared. Multiple matches (malformed,
//   non-prefix-free table): lowest i wins, no error.
//  No match and len_n == MAX_LEN: err=1, acc/len cleared, sym_cnt unchanged, stay S_DECODE.
//  No match, len_n < MAX_LEN: keep accumulating, outputs 0.
//  bit_valid=0: hold acc/len; gaps of any length between bits are legal.
//  sym_cnt == NUM_SYM-1 at a match: done=1 with that sym_valid, then S_DONE; sym_cnt holds
//   NUM_SYM until next code_valid or reset.
//  M_i == 0 marks symbol i absent (count 0); it never matches.
//  sym_out holds last symbol between pulses; sym_valid/err/done are single-cycle pulses.
//  Reset mid-frame: immediate clear of everything incl. codebook; bits ignored until code_valid.
// TESTING
//  Codebook A: HC=00,02,06,0E,1E,1F M=01,03,07,0F,1F,1F (codes 0,10,110,1110,11110,11111).
//  1) Load A; bits 1,0 on consecutive cycles -> sym_valid=1, sym_out=2 cycle after 2nd bit.
//  2) Load A; bits 0,11111,1110 -> symbols 1,6,4 in order, sym_cnt=3, err never asserted.
//  3) Load A with M6=00,HC6=00; bits 1 x8 -> err pulse after 8th bit, no sym_valid, acc clear
//     (next bit 0 -> symbol 1).
//  4) Load A; stream 100 codes from a random gray sequence with random bit_valid gaps ->
//     sym_out sequence equals source, done with 100th sym_valid, later bits ignored.
//  5) Bits before any code_valid, and bit_valid same cycle as code_valid -> both ignored;
//     first decode uses only subsequent bits.
//  6) Assert reset after bits 1,1 of code 110 -> all outputs 0, bits ignored until reload.

Source files
------------

// File: rtl/huffman_decoder_if.sv
// Codebook load and serial bit stream into the huffman decoder,
// plus decoded symbol, error and frame-done outputs coming back.
interface huffman_decoder_if;
   logic       code_valid;
   logic [7:0] HC1, HC2, HC3, HC4, HC5, HC6;
   logic [7:0] M1, M2, M3, M4, M5, M6;
   logic       bit_valid;
   logic       bit_in;
   logic       sym_valid;
   logic [7:0] sym_out;
   logic       err;
   logic       done;
   logic [7:0] sym_cnt;

   modport master (
      output code_valid,
      output HC1, HC2, HC3, HC4, HC5, HC6,
      output M1, M2, M3, M4, M5, M6,
      output bit_valid, bit_in,
      input  sym_valid, sym_out, err, done, sym_cnt
   );

   modport slave (
      input  code_valid,
      input  HC1, HC2, HC3, HC4, HC5, HC6,
      input  M1, M2, M3, M4, M5, M6,
      input  bit_valid, bit_in,
      output sym_valid, sym_out, err, done, sym_cnt
   );
endinterface

// File: rtl/huffman_decoder.sv
// Serial huffman decoder: latches a 6-entry codebook on code_valid, then
// turns one-bit-per-cycle input into symbols 1..6.
// Ports: CLK, reset (async, active-high), bus (slave side of
// huffman_decoder_if: codebook, bit stream, sym/err/done/sym_cnt outputs).
module huffman_decoder #(
   parameter int MAX_LEN = 8,
   parameter int NUM_SYM = 100
) (
   input  logic              CLK,
   input  logic              reset,
   huffman_decoder_if.slave  bus
);

   typedef enum logic [1:0] {
      S_EMPTY,
      S_DECODE,
      S_DONE
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] hc_q [6];
   logic [7:0] hc_d [6];
   logic [7:0] m_q  [6];
   logic [7:0] m_d  [6];
   logic [7:0] acc_q, acc_d;
   logic [3:0] len_q, len_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] out_q, out_d;
   logic       sv_q, sv_d;
   logic       err_q, err_d;
   logic       done_q, done_d;

   logic [7:0] acc_n;
   logic [3:0] len_n;
   logic [7:0] len_mask;
   logic       hit;
   logic [2:0] hit_idx;

   assign acc_n    = {acc_q[6:0], bus.bit_in};
   assign len_n    = len_q + 4'd1;
   // all-ones mask of the current code length; an entry can only
   // match when its mask is exactly this
   assign len_mask = 8'((9'd1 << len_n) - 9'd1);

   // scan high to low so the lowest matching index wins
   always_comb begin
      hit     = 1'b0;
      hit_idx = 3'd0;
      for (int i = 5; i >= 0; i--) begin
         if (m_q[i] != 8'd0 && m_q[i] == len_mask &&
             (acc_n & m_q[i]) == hc_q[i]) begin
            hit     = 1'b1;
            hit_idx = 3'(i + 1);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      hc_d    = hc_q;
      m_d     = m_q;
      acc_d   = acc_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      sv_d    = 1'b0;
      err_d   = 1'b0;
      done_d  = 1'b0;
      if (bus.code_valid) begin
         hc_d[0] = bus.HC1;
         hc_d[1] = bus.HC2;
         hc_d[2] = bus.HC3;
         hc_d[3] = bus.HC4;
         hc_d[4] = bus.HC5;
         hc_d[5] = bus.HC6;
         m_d[0]  = bus.M1;
         m_d[1]  = bus.M2;
         m_d[2]  = bus.M3;
         m_d[3]  = bus.M4;
         m_d[4]  = bus.M5;
         m_d[5]  = bus.M6;
         acc_d   = 8'd0;
         len_d   = 4'd0;
         cnt_d   = 8'd0;
         state_d = S_DECODE;
      end else if (state_q == S_DECODE && bus.bit_valid) begin
         if (hit) begin
            sv_d  = 1'b1;
            out_d = {5'd0, hit_idx};
            cnt_d = cnt_q + 8'd1;
            acc_d = 8'd0;
            len_d = 4'd0;
            if (cnt_q == 8'(NUM_SYM - 1)) begin
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end else if (len_n == 4'(MAX_LEN)) begin
            err_d = 1'b1;
            acc_d = 8'd0;
            len_d = 4'd0;
         end else begin
            acc_d = acc_n;
            len_d = len_n;
         end
      end
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) state_q <= S_EMPTY;
      else       state_q <= state_d;
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 6; i++) begin
            hc_q[i] <= 8'd0;
            m_q[i]  <= 8'd0;
         end
         acc_q  <= 8'd0;
         len_q  <= 4'd0;
         cnt_q  <= 8'd0;
         out_q  <= 8'd0;
         sv_q   <= 1'b0;
         err_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         hc_q   <= hc_d;
         m_q    <= m_d;
         acc_q  <= acc_d;
         len_q  <= len_d;
         cnt_q  <= cnt_d;
         out_q  <= out_d;
         sv_q   <= sv_d;
         err_q  <= err_d;
         done_q <= done_d;
      end
   end

   assign bus.sym_valid = sv_q;
   assign bus.sym_out   = out_q;
   assign bus.err       = err_q;
   assign bus.done      = done_q;
   assign bus.sym_cnt   = cnt_q;

endmodule

// File: tb/tb_huffman_decoder.sv
// Self-checking bench for huffman_decoder: behavioural codebook model
// compared every cycle, plus directed literal checks.
module tb_huffman_decoder;

   logic CLK = 1'b0;
   logic reset = 1'b1;

   huffman_decoder_if bus ();

   huffman_decoder #(
      .MAX_LEN (8),
      .NUM_SYM (100)
   ) dut (
      .CLK   (CLK),
      .reset (reset),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   logic [7:0] tb_hc [1:6];
   logic [7:0] tb_m  [1:6];

   assign bus.HC1 = tb_hc[1];
   assign bus.HC2 = tb_hc[2];
   assign bus.HC3 = tb_hc[3];
   assign bus.HC4 = tb_hc[4];
   assign bus.HC5 = tb_hc[5];
   assign bus.HC6 = tb_hc[6];
   assign bus.M1  = tb_m[1];
   assign bus.M2  = tb_m[2];
   assign bus.M3  = tb_m[3];
   assign bus.M4  = tb_m[4];
   assign bus.M5  = tb_m[5];
   assign bus.M6  = tb_m[6];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // model: 0 = no codebook, 1 = decoding, 2 = frame finished
   int md_mode = 0;
   int md_code [1:6];
   int md_len  [1:6];
   int md_val = 0, md_n = 0, md_cnt = 0;
   int e_out = 0;
   bit e_sv = 0, e_err = 0, e_done = 0;

   always @(posedge CLK or posedge reset) begin
      if (reset) begin
         md_mode = 0;
         md_val  = 0;
         md_n    = 0;
         md_cnt  = 0;
         e_out   = 0;
         e_sv    = 0;
         e_err   = 0;
         e_done  = 0;
         for (int i = 1; i <= 6; i++) begin
            md_code[i] = 0;
            md_len[i]  = 0;
         end
      end else begin
         e_sv   = 0;
         e_err  = 0;
         e_done = 0;
         if (bus.code_valid) begin
            for (int i = 1; i <= 6; i++) begin
               md_code[i] = int'(tb_hc[i]);
               md_len[i]  = $countones(tb_m[i]);
            end
            md_val  = 0;
            md_n    = 0;
            md_cnt  = 0;
            md_mode = 1;
         end else if (md_mode == 1 && bus.bit_valid) begin
            int found;
            found  = 0;
            md_val = md_val * 2 + int'(bus.bit_in);
            md_n   = md_n + 1;
            for (int i = 1; i <= 6; i++) begin
               if (found == 0 && md_len[i] != 0 && md_len[i] == md_n &&
                   md_code[i] == md_val)
                  found = i;
            end
            if (found != 0) begin
               e_sv   = 1;
               e_out  = found;
               md_cnt = md_cnt + 1;
               md_val = 0;
               md_n   = 0;
               if (md_cnt == 100) begin
                  e_done  = 1;
                  md_mode = 2;
               end
            end else if (md_n == 8) begin
               e_err  = 1;
               md_val = 0;
               md_n   = 0;
            end
         end
      end
   end

   int got[$];
   int n_err  = 0;
   int n_done = 0;

   always @(negedge CLK) begin
      check("sym_valid", bus.sym_valid, e_sv);
      check("sym_out", bus.sym_out, e_out);
      check("err", bus.err, e_err);
      check("done", bus.done, e_done);
      check("sym_cnt", bus.sym_cnt, md_cnt);
      if (bus.sym_valid === 1'b1) got.push_back(int'(bus.sym_out));
      if (bus.err === 1'b1) n_err++;
      if (bus.done === 1'b1) n_done++;
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic send_bit(input bit b);
      bus.bit_valid = 1'b1;
      bus.bit_in    = b;
      @(posedge CLK);
      #1;
      bus.bit_valid = 1'b0;
   endtask

   task automatic load(input bit bv, input bit bi);
      bus.code_valid = 1'b1;
      bus.bit_valid  = bv;
      bus.bit_in     = bi;
      @(posedge CLK);
      #1;
      bus.code_valid = 1'b0;
      bus.bit_valid  = 1'b0;
   endtask

   task automatic set_a();
      int c [1:6];
      c = '{0, 2, 6, 14, 30, 31};
      for (int i = 1; i <= 6; i++) begin
         tb_hc[i] = 8'(c[i]);
         tb_m[i]  = 8'((1 << (i < 6 ? i : 5)) - 1);
      end
   endtask

   task automatic send_sym(input int s, input bit gaps);
      int code, len;
      len  = (s < 6) ? s : 5;
      code = (s == 6) ? 31 : ((1 << s) - 2);
      for (int b = len - 1; b >= 0; b--) begin
         if (gaps) idle($urandom_range(0, 2));
         send_bit(bit'((code >> b) & 1));
      end
   endtask

   initial begin
      int src[$];
      int e0, d0;
      bus.code_valid = 1'b0;
      bus.bit_valid  = 1'b0;
      bus.bit_in     = 1'b0;
      set_a();
      repeat (3) @(posedge CLK);
      #1;
      check("reset_sym_cnt", bus.sym_cnt, 0);
      check("reset_sym_out", bus.sym_out, 0);
      reset = 1'b0;
      idle(1);

      // bits before any codebook, then a bit alongside the load
      send_bit(1);
      send_bit(0);
      idle(2);
      check("pre_load_ignored", got.size(), 0);
      load(1'b1, 1'b1);
      send_bit(0);
      idle(2);
      check("load_bit_dropped_n", got.size(), 1);
      check("load_bit_dropped_sym", got[0], 1);

      // code 10 back to back
      load(1'b0, 1'b0);
      got.delete();
      send_bit(1);
      send_bit(0);
      check("t1_valid", bus.sym_valid, 1);
      check("t1_sym", bus.sym_out, 2);

      // 0, 11111, 1110
      load(1'b0, 1'b0);
      got.delete();
      e0 = n_err;
      send_sym(1, 1'b0);
      send_sym(6, 1'b0);
      send_sym(4, 1'b0);
      idle(2);
      check("t2_n", got.size(), 3);
      check("t2_s0", got[0], 1);
      check("t2_s1", got[1], 6);
      check("t2_s2", got[2], 4);
      check("t2_cnt", bus.sym_cnt, 3);
      check("t2_err", n_err - e0, 0);

      // symbol 6 absent: eight ones overflow
      tb_hc[6] = 8'h00;
      tb_m[6]  = 8'h00;
      load(1'b0, 1'b0);
      got.delete();
      e0 = n_err;
      repeat (8) send_bit(1);
      idle(2);
      check("t3_err", n_err - e0, 1);
      check("t3_nosym", got.size(), 0);
      send_bit(0);
      idle(2);
      check("t3_after_n", got.size(), 1);
      check("t3_after_sym", got[0], 1);
      set_a();

      // full random frame with gaps
      load(1'b0, 1'b0);
      got.delete();
      d0 = n_done;
      for (int k = 0; k < 100; k++) begin
         int s;
         s = $urandom_range(1, 6);
         src.push_back(s);
         send_sym(s, 1'b1);
      end
      idle(2);
      check("t4_n", got.size(), 100);
      for (int k = 0; k < 100 && k < got.size(); k++)
         check("t4_seq", got[k], src[k]);
      check("t4_done", n_done - d0, 1);
      check("t4_cnt", bus.sym_cnt, 100);
      repeat (20) send_bit(bit'($urandom_range(0, 1)));
      idle(2);
      check("t4_post_n", got.size(), 100);
      check("t4_post_cnt", bus.sym_cnt, 100);

      // reset in the middle of code 110
      load(1'b0, 1'b0);
      got.delete();
      send_bit(1);
      send_bit(1);
      reset = 1'b1;
      #1;
      check("t6_valid", bus.sym_valid, 0);
      check("t6_sym", bus.sym_out, 0);
      check("t6_err", bus.err, 0);
      check("t6_done", bus.done, 0);
      check("t6_cnt", bus.sym_cnt, 0);
      #2;
      reset = 1'b0;
      @(posedge CLK);
      #1;
      send_bit(0);
      send_bit(0);
      idle(2);
      check("t6_ignored", got.size(), 0);
      load(1'b0, 1'b0);
      send_bit(0);
      idle(2);
      check("t6_reload_n", got.size(), 1);
      check("t6_reload_sym", got[0], 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
